bitwise_result_checker: RTL

Response-side checker for the bitwise-operation datapath. It accepts operand/result tuples (A, B, A&B, A|B, A^B) over a valid/ready handshake and recomputes the expected results in a registered compare stage. It reports a per-sample pass/fail pulse and keeps saturating pass/fail counters, plus a sticky error flag with optional halt. It sits at the consuming end of any bitwise_oper-style producer, in both benches and on-chip self-test.

---
 rtl/bitwise_result_checker_if.sv | 35 +++
 rtl/bitwise_result_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bitwise_result_checker_if.sv
// ---------------------------------------------------------------------------
// bitwise_result_checker_if
//   Operand/result tuple bus between a bitwise_oper-style producer and the
//   bitwise_result_checker. A tuple transfers on a rising edge where
//   in_valid & in_ready are both high.
//
//   Signals:
//     in_valid        producer -> checker  tuple present on a/b/ab_*
//     in_ready        checker  -> producer checker can accept this cycle
//     a, b            producer -> checker  operands (WIDTH bits)
//     ab_and/or/xor   producer -> checker  results under test (WIDTH bits)
//
//   Modports: master (producer side), slave (checker side).
// ---------------------------------------------------------------------------
interface bitwise_result_checker_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] ab_and;
    logic [WIDTH-1:0] ab_or;
    logic [WIDTH-1:0] ab_xor;

    modport master (
        output in_valid, a, b, ab_and, ab_or, ab_xor,
        input  in_ready
    );

    modport slave (
        input  in_valid, a, b, ab_and, ab_or, ab_xor,
        output in_ready
    );
endinterface

// File: rtl/bitwise_result_checker.sv
// ---------------------------------------------------------------------------
// bitwise_result_checker
//   Response-side checker for a bitwise-operation datapath. Each accepted
//   tuple (A, B, A&B, A|B, A^B) is captured in stage 1 and re-evaluated in
//   stage 2; stage 2 produces a one-cycle pass/fail pulse, saturating
//   pass/fail counters, a sticky error flag and (optionally) a capture of
//   the first failing tuple. With halt_on_err set, acceptance stops once the
//   error flag is up.
//
//   Optional feature macro: BWCHK_CAPTURE_EN
//     defined     -> err_mask_o / err_a_o / err_b_o hold the first failure
//     not defined -> no capture registers, those outputs are tied to 0
//
//   Ports:
//     clk            clock, all logic on the rising edge
//     rst_n          synchronous active-low reset
//     bus            tuple bus (slave modport): in_valid, in_ready, a, b,
//                    ab_and, ab_or, ab_xor
//     halt_on_err_i  stop accepting while err_flag_o is set
//     clr_i          synchronous clear of counters, error flag, captures
//     out_valid_o    one-cycle pulse per evaluated sample
//     out_pass_o     pass result of that sample (valid with out_valid_o)
//     pass_cnt_o     saturating pass count
//     fail_cnt_o     saturating fail count
//     err_flag_o     sticky: at least one failure since reset/clear
//     err_mask_o     {xor_bad, or_bad, and_bad} of the first failure
//     err_a_o        operand A of the first failure
//     err_b_o        operand B of the first failure
// ---------------------------------------------------------------------------
module bitwise_result_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bitwise_result_checker_if.slave bus,
    input  logic                 halt_on_err_i,
    input  logic                 clr_i,
    output logic                 out_valid_o,
    output logic                 out_pass_o,
    output logic [CNT_W-1:0]     pass_cnt_o,
    output logic [CNT_W-1:0]     fail_cnt_o,
    output logic                 err_flag_o,
    output logic [2:0]           err_mask_o,
    output logic [WIDTH-1:0]     err_a_o,
    output logic [WIDTH-1:0]     err_b_o
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             accept;
    logic             vld_p1_q;
    logic [WIDTH-1:0] a_p1_q;
    logic [WIDTH-1:0] b_p1_q;
    logic [WIDTH-1:0] and_p1_q;
    logic [WIDTH-1:0] or_p1_q;
    logic [WIDTH-1:0] xor_p1_q;

    logic [2:0]       bad_mask;
    logic             sample_fail;

    logic             out_valid_q;
    logic             out_pass_q;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             err_flag_q, err_flag_d;

    // Ready depends on the registered flag, so a failure throttles the
    // producer only from the cycle after it is evaluated.
    assign bus.in_ready = rst_n & ~(err_flag_q & halt_on_err_i);
    assign accept       = bus.in_valid & bus.in_ready;

    // ---- Stage 1: capture --------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1_q   <= bus.a;
            b_p1_q   <= bus.b;
            and_p1_q <= bus.ab_and;
            or_p1_q  <= bus.ab_or;
            xor_p1_q <= bus.ab_xor;
        end
    end

    // ---- Stage 2: evaluate -------------------------------------------------
    always_comb begin
        bad_mask[0] = (and_p1_q != (a_p1_q & b_p1_q));
        bad_mask[1] = (or_p1_q  != (a_p1_q | b_p1_q));
        bad_mask[2] = (xor_p1_q != (a_p1_q ^ b_p1_q));
        sample_fail = |bad_mask;
    end

    // Clear takes priority over any same-edge update.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        err_flag_d = err_flag_q;
        if (clr_i) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_flag_d = 1'b0;
        end else if (vld_p1_q) begin
            if (sample_fail) begin
                fail_cnt_d = sat_inc(fail_cnt_q);
                err_flag_d = 1'b1;
            end else begin
                pass_cnt_d = sat_inc(pass_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pass_q  <= 1'b0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            err_flag_q  <= 1'b0;
        end else begin
            // The pulse is reported even when clr_i wipes the counters.
            out_valid_q <= vld_p1_q;
            out_pass_q  <= vld_p1_q & ~sample_fail;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            err_flag_q  <= err_flag_d;
        end
    end

`ifdef BWCHK_CAPTURE_EN
    logic [2:0]       err_mask_q, err_mask_d;
    logic [WIDTH-1:0] err_a_q, err_a_d;
    logic [WIDTH-1:0] err_b_q, err_b_d;

    // Only the first failure after reset/clear is recorded.
    always_comb begin
        err_mask_d = err_mask_q;
        err_a_d    = err_a_q;
        err_b_d    = err_b_q;
        if (clr_i) begin
            err_mask_d = '0;
            err_a_d    = '0;
            err_b_d    = '0;
        end else if (vld_p1_q && sample_fail && !err_flag_q) begin
            err_mask_d = bad_mask;
            err_a_d    = a_p1_q;
            err_b_d    = b_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_mask_q <= '0;
            err_a_q    <= '0;
            err_b_q    <= '0;
        end else begin
            err_mask_q <= err_mask_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
        end
    end

    assign err_mask_o = err_mask_q;
    assign err_a_o    = err_a_q;
    assign err_b_o    = err_b_q;
`else
    assign err_mask_o = '0;
    assign err_a_o    = '0;
    assign err_b_o    = '0;
`endif

    assign out_valid_o = out_valid_q;
    assign out_pass_o  = out_pass_q;
    assign pass_cnt_o  = pass_cnt_q;
    assign fail_cnt_o  = fail_cnt_q;
    assign err_flag_o  = err_flag_q;

endmodule
